// File: rtl/pipe_if_stage_pkg.sv
// Shared pipeline definitions: next-PC select codes,
// bubble instruction and reset vector.
package pipe_if_stage_pkg;

    localparam logic [31:0] NOP_INST_C = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_C = 32'h0000_0000;

    typedef enum logic [1:0] {
        PCS_SEQ = 2'b00,
        PCS_BR  = 2'b01,
        PCS_JR  = 2'b10,
        PCS_J   = 2'b11
    } pcsrc_t;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HAVE = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pipe_npc.sv
// Next-PC mux: sequential, branch, register jump
// or jump target.
module pipe_npc
    import pipe_if_stage_pkg::*;
(
    input  logic [31:0] pc4,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    input  logic [1:0]  pcsource,
    output logic [31:0] npc
);

    // pick the target named by pcsource
    always_comb begin
        npc = pc4;
        unique case (1'b1)
            pcsource == PCS_BR: npc = bpc;
            pcsource == PCS_JR: npc = rpc;
            pcsource == PCS_J:  npc = jpc;
            default:            npc = pc4;
        endcase
    end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction fetch stage: one outstanding request,
// same-cycle ack bypass, held instruction and redirect.
module pipe_if_stage
    import pipe_if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_C,
    parameter logic [31:0] NOP_INST = NOP_INST_C
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        nostall,
    input  logic [1:0]  pcsource,
    input  logic [31:0] bpc,
    input  logic [31:0] rpc,
    input  logic [31:0] jpc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] pc4,
    output logic        fetch_busy
);

    fetch_state_t state_q;
    fetch_state_t state_d;
    logic [31:0]  pc_q;
    logic [31:0]  ibuf;
    logic [31:0]  redir_pc;
    logic         redir_valid;
    logic [31:0]  npc;
    logic [31:0]  pc_next;
    logic         redirect;
    logic         advance;
    logic         hold_load;

    assign pc4       = pc_q + 32'd4;
    assign imem_addr = pc_q;
    assign redirect  = nostall & (pcsource != PCS_SEQ);

    pipe_npc u_npc (
        .pc4      (pc4),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .pcsource (pcsource),
        .npc      (npc)
    );

    // a live redirect beats a stored one, which beats pc+4
    assign pc_next = redirect    ? npc :
                     redir_valid ? redir_pc :
                                   pc4;

    // fetch FSM outputs and next state
    always_comb begin
        state_d    = state_q;
        imem_req   = 1'b0;
        inst       = ibuf;
        fetch_busy = 1'b0;
        advance    = 1'b0;
        hold_load  = 1'b0;
        unique case (state_q)
            S_REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    inst    = imem_rdata;
                    advance = nostall;
                    if (!nostall) begin
                        hold_load = 1'b1;
                        state_d   = S_HAVE;
                    end
                end else begin
                    inst       = NOP_INST;
                    fetch_busy = 1'b1;
                end
            end
            S_HAVE: begin
                advance = nostall;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
        if (advance) begin
            state_d = S_REQ;
        end
    end

    // fetch state and held instruction word
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_REQ;
            ibuf    <= NOP_INST;
        end else begin
            state_q <= state_d;
            if (hold_load) begin
                ibuf <= imem_rdata;
            end
        end
    end

    // fetch PC and pending-redirect bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            redir_valid <= 1'b0;
            redir_pc    <= 32'h0;
        end else if (advance) begin
            pc_q        <= pc_next;
            redir_valid <= 1'b0;
        end else if (redirect) begin
            redir_valid <= 1'b1;
            redir_pc    <= npc;
        end
    end

endmodule

// File: doc/pipe_if_stage.md
PIPE_IF_STAGE -- requirements
Module: pipe_if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0000 (sll $0,$0,0), is the bubble instruction.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 nostall  input  1  from hazard unit; 1 = IF/ID register loads this cycle.
REQ-006 pcsource  input  2  next-PC select: 00 pc+4, 01 branch (bpc), 10 register jump (rpc), 11 jump (jpc).
REQ-007 bpc, rpc, jpc  input  32 each  branch, jr and j targets from the decode stage.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  32  fetch address (word aligned).
REQ-010 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-011 imem_rdata  input  32  fetched instruction word.
REQ-012 inst  output  32  instruction to the IF/ID register.
REQ-013 pc4  output  32  PC+4 of inst to the IF/ID register.
REQ-014 fetch_busy  output  1  1 = inst is a bubble (fetch outstanding).

Function
REQ-015 Block SHALL hold pc_q (current fetch PC), a 2-state FSM {S_REQ, S_HAVE}, ibuf (32b), redir_valid (1b) and redir_pc (32b).
REQ-016 S_REQ: imem_req=1, imem_addr=pc_q; without imem_ack: inst=NOP_INST, fetch_busy=1.
REQ-017 S_REQ with imem_ack: inst=imem_rdata (same-cycle bypass), fetch_busy=0.
REQ-018 S_HAVE: imem_req=0, inst=ibuf, fetch_busy=0.
REQ-019 pc4 SHALL always equal pc_q+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
REQ-020 advance = ~fetch_busy & nostall; on advance pc_q <= next PC and FSM <= S_REQ.
REQ-021 Next PC priority: redirect sampled this cycle (pcsource!=00 and nostall=1) > redir_pc if redir_valid > pc_q+4.
REQ-022 Targets: 01 -> bpc, 10 -> rpc, 11 -> jpc; the instruction at pc_q is the delay slot and is never discarded.
REQ-023 S_REQ, imem_ack=1, nostall=0: ibuf <= imem_rdata, FSM <= S_HAVE, pc_q unchanged.
REQ-024 S_REQ, imem_ack=0: pc_q and FSM unchanged; imem_addr stays stable until ack (no abort, no re-issue).
REQ-025 Redirect with nostall=1 on a non-advance cycle: redir_valid <= 1, redir_pc <= selected target.
REQ-026 Redirect while redir_valid=1: new target overwrites redir_pc.
REQ-027 redir_valid SHALL clear on the advance that consumes it.
REQ-028 pcsource is ignored when nostall=0.
REQ-029 imem_ack in S_HAVE SHALL be ignored.
REQ-030 Fetch latency: minimum 0 cycles (ack in the request cycle); sustained throughput 1 instruction/cycle when ack is held high.

Reset
REQ-031 When rst=1 at a rising edge: pc_q <= RESET_PC, FSM <= S_REQ, redir_valid <= 0, redir_pc <= 0, ibuf <= NOP_INST.
REQ-032 Output values after that edge: imem_req=1, imem_addr=RESET_PC, inst=NOP_INST, pc4=RESET_PC+4, fetch_busy=1.
REQ-033 Reset mid-fetch abandons the in-flight request; imem_ack in a reset cycle SHALL be ignored.
REQ-034 Reset SHALL override advance, redirect and ack in the same cycle.

Structure
REQ-035 Shared pipeline package SHALL hold the pcsource encodings, NOP_INST and the RESET_PC default.
REQ-036 The next-PC mux SHALL be one combinational sub-module, pipe_npc (pc4, bpc, rpc, jpc, pcsource -> npc).

Verification
REQ-037 Reset, then ack every cycle, nostall=1 -> imem_addr 0x0, 0x4, 0x8 on consecutive cycles; pc4 0x4, 0x8, 0xC.
REQ-038 Ack delayed 3 cycles at pc 0x10 -> inst=NOP_INST and fetch_busy=1 for 3 cycles; imem_addr held at 0x10; rdata delivered on cycle 4.
REQ-039 Ack at pc 0x20 with nostall=0 for 2 cycles -> FSM in S_HAVE, imem_req=0, inst=ibuf; on nostall=1 next imem_addr=0x24.
REQ-040 pcsource=01, bpc=0x100 on an advance from pc 0x30 -> next imem_addr=0x100.
REQ-041 pcsource=11, jpc=0x200 while fetch of 0x40 is pending -> 0x40 completes first, then imem_addr=0x200; redir_valid clears.
REQ-042 rst pulsed while waiting on pc 0x80 with a pending redirect -> imem_addr=RESET_PC, fetch_busy=1, redirect discarded.
